bsg_cache_pkt_burst_issuer: RTL and testbench

BSG_CACHE_PKT_BURST_ISSUER -- requirements
Module: bsg_cache_pkt_burst_issuer

---
 rtl/bsg_cache_pkt_burst_issuer.sv | 149 ++++++++++++++
 tb/tb_bsg_cache_pkt_burst_issuer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_pkt_burst_issuer.sv
// rtl/bsg_cache_pkt_burst_issuer.sv - expands one command into a burst of cache packets with bounded outstanding responses
module bsg_cache_pkt_burst_issuer #(
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 32,
  parameter int max_out_p     = 4,
  parameter int block_bytes_p = 32,
  localparam int mask_width_lp = data_width_p/8,
  localparam int out_width_lp  = $clog2(max_out_p+1),
  localparam int pkt_width_lp  = 5+addr_width_p+data_width_p+mask_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_op_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [data_width_p-1:0] cmd_data_i,
  input  logic [7:0]              cmd_len_i,
  output logic [pkt_width_lp-1:0] cache_pkt_o,
  output logic                    v_o,
  input  logic                    ready_i,
  input  logic                    data_v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    yumi_o,
  output logic                    rsp_v_o,
  output logic [data_width_p-1:0] rsp_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [4:0] op_lw_lp    = 5'h02;
  localparam logic [4:0] op_sw_lp    = 5'h0A;
  localparam logic [4:0] op_sb_lp    = 5'h08;
  localparam logic [4:0] op_sh_lp    = 5'h09;
  localparam logic [4:0] op_afl_lp   = 5'h13;
  localparam logic [4:0] op_ainv_lp  = 5'h15;
  localparam logic [4:0] op_tagst_lp = 5'h10;

  state_e                    state_r, state_n;
  logic [out_width_lp-1:0]   outstanding_r, outstanding_n;
  logic [7:0]                remaining_r;
  logic [4:0]                opcode_r;
  logic [addr_width_p-1:0]   addr_r, stride_r;
  logic [data_width_p-1:0]   data_r;
  logic                      done_r, done_n;
  logic                      rsp_v_r;
  logic [data_width_p-1:0]   rsp_data_r;

  logic [4:0]                cmd_opcode;
  logic [addr_width_p-1:0]   cmd_stride;
  logic                      cmd_store;
  logic [mask_width_lp-1:0]  mask;
  logic                      issue, rsp_take;

  always_comb begin
    cmd_opcode = op_lw_lp;
    cmd_stride = addr_width_p'(4);
    cmd_store  = 1'b0;
    case (cmd_op_i)
      3'd1: begin cmd_opcode = op_sw_lp;    cmd_store = 1'b1; end
      3'd2: begin cmd_opcode = op_sb_lp;    cmd_store = 1'b1; cmd_stride = addr_width_p'(1); end
      3'd3: begin cmd_opcode = op_sh_lp;    cmd_store = 1'b1; cmd_stride = addr_width_p'(2); end
      3'd4: begin cmd_opcode = op_afl_lp;   cmd_stride = addr_width_p'(block_bytes_p); end
      3'd5: begin cmd_opcode = op_ainv_lp;  cmd_stride = addr_width_p'(block_bytes_p); end
      3'd6: begin cmd_opcode = op_tagst_lp; cmd_stride = addr_width_p'(block_bytes_p); end
      default: ;
    endcase
  end

  // Mask follows the current beat address so sub-word bursts walk the byte lanes.
  always_comb begin
    mask = '1;
    if (opcode_r == op_sb_lp)
      mask = mask_width_lp'(1) << addr_r[1:0];
    else if (opcode_r == op_sh_lp)
      mask = mask_width_lp'(3) << {addr_r[1], 1'b0};
  end

  assign v_o      = (state_r == ISSUE) && (outstanding_r < out_width_lp'(max_out_p));
  assign issue    = v_o & ready_i;
  assign rsp_take = data_v_i & (outstanding_r != '0);

  always_comb begin
    outstanding_n = outstanding_r;
    if (issue && !rsp_take)
      outstanding_n = outstanding_r + out_width_lp'(1);
    else if (!issue && rsp_take)
      outstanding_n = outstanding_r - out_width_lp'(1);
  end

  always_comb begin
    state_n     = state_r;
    cmd_ready_o = 1'b0;
    done_n      = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) state_n = ISSUE;
      end
      ISSUE: if (issue && remaining_r == 8'd0) state_n = DRAIN;
      DRAIN: if (outstanding_n == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      outstanding_r <= '0;
      remaining_r   <= '0;
      opcode_r      <= '0;
      addr_r        <= '0;
      stride_r      <= '0;
      data_r        <= '0;
      done_r        <= 1'b0;
      rsp_v_r       <= 1'b0;
      rsp_data_r    <= '0;
    end else begin
      state_r       <= state_n;
      outstanding_r <= outstanding_n;
      done_r        <= done_n;
      rsp_v_r       <= data_v_i;
      rsp_data_r    <= data_i;
      if (state_r == IDLE && cmd_v_i) begin
        opcode_r    <= cmd_opcode;
        addr_r      <= cmd_addr_i;
        stride_r    <= cmd_stride;
        data_r      <= cmd_store ? cmd_data_i : '0;
        remaining_r <= cmd_len_i;
      end else if (issue) begin
        addr_r <= addr_r + stride_r;
        if (remaining_r != 8'd0) remaining_r <= remaining_r - 8'd1;
      end
    end
  end

  assign cache_pkt_o = {opcode_r, addr_r, data_r, mask};
  assign yumi_o      = data_v_i;
  assign rsp_v_o     = rsp_v_r;
  assign rsp_data_o  = rsp_data_r;
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;

endmodule

// File: tb/tb_bsg_cache_pkt_burst_issuer.sv
// tb/tb_bsg_cache_pkt_burst_issuer.sv - directed self-checking bench for bsg_cache_pkt_burst_issuer
module tb_bsg_cache_pkt_burst_issuer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [7:0]  cmd_len_i;
  logic [72:0] cache_pkt_o;
  logic        v_o;
  logic        ready_i;
  logic        data_v_i;
  logic [31:0] data_i;
  logic        yumi_o;
  logic        rsp_v_o;
  logic [31:0] rsp_data_o;
  logic        busy_o;
  logic        done_o;

  bsg_cache_pkt_burst_issuer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_len_i(cmd_len_i),
    .cache_pkt_o(cache_pkt_o), .v_o(v_o), .ready_i(ready_i),
    .data_v_i(data_v_i), .data_i(data_i), .yumi_o(yumi_o),
    .rsp_v_o(rsp_v_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [7:0]       len;
    logic [4:0]       opc;
    logic [31:0]      exp_data;
    logic [3:0][31:0] exp_addr;
    logic [3:0][3:0]  exp_mask;
  } cmd_vec_t;

  int          checks = 0, failures = 0;
  int          issued, responded, dones, rmode;
  bit          man_dv, prev_dv;
  logic [31:0] prev_d;
  logic [1:0]  pipe;
  cmd_vec_t    vecs[9];
  logic [72:0] snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cmd_vec_t mk(input logic [2:0] op, input logic [31:0] addr, data,
                                  input logic [7:0] len, input logic [4:0] opc, input logic [31:0] edata,
                                  input logic [31:0] a0, a1, a2, a3, input logic [3:0] m0, m1, m2, m3);
    cmd_vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.len = len; v.opc = opc; v.exp_data = edata;
    v.exp_addr = {a3, a2, a1, a0};
    v.exp_mask = {m3, m2, m1, m0};
    return v;
  endfunction

  // One cycle from a negedge to the next: check forwarded response, drive response source.
  task automatic tick();
    bit iss;
    int owed;
    check("rsp_v", 32'(rsp_v_o), 32'(prev_dv));
    if (prev_dv) check("rsp_data", rsp_data_o, prev_d);
    if (done_o) begin
      dones++;
      check("done_after_last_rsp", 32'(issued - responded), 32'd0);
    end
    owed = issued - responded;
    iss  = v_o && ready_i;
    case (rmode)
      0: data_v_i = pipe[1];
      1: data_v_i = 1'b0;
      2: data_v_i = (owed > 0);
      default: data_v_i = man_dv;
    endcase
    pipe    = {pipe[0], iss};
    data_i  = $urandom;
    prev_dv = data_v_i;
    prev_d  = data_i;
    if (data_v_i) responded++;
    if (iss) issued++;
    @(negedge clk_i);
  endtask

  task automatic clear_counts();
    issued = 0; responded = 0; dones = 0; pipe = '0;
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [31:0] a, d, input logic [7:0] len);
    check("cmd_ready", 32'(cmd_ready_o), 32'd1);
    cmd_v_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d; cmd_len_i = len;
    tick();
    cmd_v_i = 1'b0;
    check("busy", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int cyc = 0;
    while (dones == 0 && cyc < bound) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(dones), 32'd1);
  endtask

  task automatic run_vec(input cmd_vec_t v, input int idx);
    int cyc = 0;
    clear_counts();
    rmode = 0; ready_i = 1'b1;
    start_cmd(v.op, v.addr, v.data, v.len);
    while (dones == 0 && cyc < 1000) begin
      if (v_o && issued < 4) begin
        check($sformatf("v%0d_b%0d_opcode", idx, issued), 32'(cache_pkt_o[72:68]), 32'(v.opc));
        check($sformatf("v%0d_b%0d_addr", idx, issued), cache_pkt_o[67:36], v.exp_addr[issued]);
        check($sformatf("v%0d_b%0d_data", idx, issued), cache_pkt_o[35:4], v.exp_data);
        check($sformatf("v%0d_b%0d_mask", idx, issued), 32'(cache_pkt_o[3:0]), 32'(v.exp_mask[issued]));
      end
      tick();
      cyc++;
    end
    check($sformatf("v%0d_done", idx), 32'(dones), 32'd1);
    check($sformatf("v%0d_issued", idx), 32'(issued), 32'(v.len) + 32'd1);
    tick(); tick();
    check($sformatf("v%0d_single_done", idx), 32'(dones), 32'd1);
    check($sformatf("v%0d_idle", idx), 32'(busy_o), 32'd0);
  endtask

  initial begin
    reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_data_i = '0;
    cmd_len_i = '0; ready_i = 1'b0; data_v_i = 1'b0; data_i = '0;
    man_dv = 1'b0; prev_dv = 1'b0; prev_d = '0; rmode = 1;
    clear_counts();

    vecs[0] = mk(3'd1, 32'h100, 32'hDEADBEEF, 8'd3, 5'h0A, 32'hDEADBEEF,
                 32'h100, 32'h104, 32'h108, 32'h10C, 4'hF, 4'hF, 4'hF, 4'hF);
    vecs[1] = mk(3'd2, 32'h203, 32'h000000AB, 8'd2, 5'h08, 32'h000000AB,
                 32'h203, 32'h204, 32'h205, 32'h0, 4'b1000, 4'b0001, 4'b0010, 4'h0);
    vecs[2] = mk(3'd3, 32'h102, 32'h00001234, 8'd2, 5'h09, 32'h00001234,
                 32'h102, 32'h104, 32'h106, 32'h0, 4'b1100, 4'b0011, 4'b1100, 4'h0);
    vecs[3] = mk(3'd4, 32'hFFFFFFE0, 32'h55555555, 8'd1, 5'h13, 32'h0,
                 32'hFFFFFFE0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0);
    vecs[4] = mk(3'd5, 32'h40, 32'h12345678, 8'd0, 5'h15, 32'h0,
                 32'h40, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
    vecs[5] = mk(3'd6, 32'h1000, 32'h0, 8'd2, 5'h10, 32'h0,
                 32'h1000, 32'h1020, 32'h1040, 32'h0, 4'hF, 4'hF, 4'hF, 4'h0);
    vecs[6] = mk(3'd7, 32'hFFC, 32'hAAAA5555, 8'd1, 5'h02, 32'h0,
                 32'hFFC, 32'h1000, 32'h0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0);
    vecs[7] = mk(3'd0, 32'h10, 32'h0, 8'd3, 5'h02, 32'h0,
                 32'h10, 32'h14, 32'h18, 32'h1C, 4'hF, 4'hF, 4'hF, 4'hF);
    vecs[8] = mk(3'd0, 32'h0, 32'hFFFFFFFF, 8'd255, 5'h02, 32'h0,
                 32'h0, 32'h4, 32'h8, 32'hC, 4'hF, 4'hF, 4'hF, 4'hF);

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_v", 32'(v_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_rsp_v", 32'(rsp_v_o), 32'd0);
    check("rst_pkt_opcode", 32'(cache_pkt_o[72:68]), 32'd0);
    check("rst_pkt_addr", cache_pkt_o[67:36], 32'd0);
    check("rst_pkt_data", cache_pkt_o[35:4], 32'd0);
    reset_n_i = 1'b1;
    check("rst_release_ready", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // LW len 7 against a silent response channel: issue window is max_out deep
    clear_counts(); rmode = 3; man_dv = 1'b0; ready_i = 1'b1;
    start_cmd(3'd0, 32'h400, 32'h0, 8'd7);
    repeat (8) tick();
    check("bp_issued_window", 32'(issued), 32'd4);
    check("bp_v_dropped", 32'(v_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      man_dv = 1'b1;
      tick();
      man_dv = 1'b0;
      check($sformatf("bp_reenable_%0d", k), 32'(v_o), 32'd1);
      tick();
      check($sformatf("bp_one_issue_%0d", k), 32'(issued), 32'(5 + k));
      check($sformatf("bp_v_low_%0d", k), 32'(v_o), 32'd0);
    end
    rmode = 2;
    wait_done(100);
    check("bp_total_issued", 32'(issued), 32'd8);

    // Stall with ready_i low, then simultaneous issue and response
    clear_counts(); rmode = 1; ready_i = 1'b1;
    start_cmd(3'd1, 32'h500, 32'hCAFEF00D, 8'd5);
    tick(); tick();
    ready_i = 1'b0;
    snap = cache_pkt_o;
    check("stall_addr", cache_pkt_o[67:36], 32'h508);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_v_%0d", k), 32'(v_o), 32'd1);
      check($sformatf("stall_pkt_%0d", k), 32'(cache_pkt_o == snap), 32'd1);
      tick();
    end
    check("stall_no_issue", 32'(issued), 32'd2);
    ready_i = 1'b1; rmode = 3; man_dv = 1'b1;
    tick();
    man_dv = 1'b0;
    repeat (5) tick();
    check("joint_issued", 32'(issued), 32'd5);
    check("joint_v_low", 32'(v_o), 32'd0);
    rmode = 2;
    wait_done(100);
    check("stall_total_issued", 32'(issued), 32'd6);

    // Reset in the middle of a burst with two packets outstanding
    clear_counts(); rmode = 1; ready_i = 1'b1;
    start_cmd(3'd0, 32'h600, 32'h0, 8'd7);
    tick(); tick();
    check("mid_v_before_rst", 32'(v_o), 32'd1);
    #1 reset_n_i = 1'b0;
    #1;
    check("mid_rst_v", 32'(v_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    check("mid_release_ready", 32'(cmd_ready_o), 32'd1);
    clear_counts(); prev_dv = 1'b0;
    rmode = 3; man_dv = 1'b1;
    tick(); tick();
    man_dv = 1'b0;
    repeat (4) tick();
    check("mid_no_done", 32'(dones), 32'd0);
    check("mid_stale_idle", 32'(busy_o), 32'd0);

    // Counter must have saturated at zero despite the stale responses
    clear_counts(); rmode = 1;
    start_cmd(3'd0, 32'h700, 32'h0, 8'd4);
    repeat (8) tick();
    check("sat_issued_window", 32'(issued), 32'd4);
    check("sat_v_low", 32'(v_o), 32'd0);
    rmode = 2;
    wait_done(100);
    check("sat_total_issued", 32'(issued), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
